// File: rtl/spi_master_ctl.sv
// SPI mode-0 master issuing one 16-bit {rw, addr[6:0], data} transaction per start.
// Define SPI_MISO_SYNC_EN to pass miso through a two-flop synchroniser (needs CLK_DIV >= 3).
module spi_master_ctl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int               CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [4:0]       BITS     = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_cnt;
    logic [15:0]      tx;
    logic [7:0]       rx;
    logic             sck_q;
    logic             phase_end;
    logic             accept;
    logic             miso_s;

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_div_range
        $error("spi_master_ctl: CLK_DIV must be in 1..255");
    end

`ifdef SPI_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_div_sync
        $error("spi_master_ctl: CLK_DIV must be >= 3 with the miso synchroniser");
    end

    logic [1:0] miso_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_sync <= 2'b00;
        end else begin
            miso_sync <= {miso_sync[0], miso};
        end
    end

    assign miso_s = miso_sync[1];
`else
    assign miso_s = miso;
`endif

    assign phase_end = (cnt == CNT_LAST);
    assign accept    = start && !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last GAP cycle doubles as an idle cycle, so a waiting start begins the next frame at once.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   if (phase_end) state_next = SHIFT;
            SHIFT:   if (phase_end && !sck_q && bit_cnt == BITS) state_next = HOLD;
            HOLD:    if (phase_end) state_next = GAP;
            GAP:     if (phase_end) state_next = accept ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done = (state == GAP) && phase_end;
        busy = (state != IDLE) && !done;
        nss  = !(state == SETUP || state == SHIFT || state == HOLD);
        sck  = sck_q;
        mosi = (state == SETUP || state == SHIFT) ? tx[15] : 1'b0;
    end

    // sck falls, miso is sampled and tx advances all on the same edge; tx drains to zero after 16 shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            sck_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == IDLE || phase_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            if (accept) begin
                tx      <= {rw, addr, rw ? 8'h00 : wdata};
                bit_cnt <= '0;
            end

            case (state)
                SETUP: begin
                    if (phase_end) sck_q <= 1'b1;
                end
                SHIFT: begin
                    if (phase_end) begin
                        if (sck_q) begin
                            sck_q   <= 1'b0;
                            rx      <= {rx[6:0], miso_s};
                            tx      <= {tx[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end else if (bit_cnt != BITS) begin
                            sck_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (phase_end) rdata <= rx;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
